// File: rtl/ram_lsu_if.sv
// Request/response and RAM-side bus of the load/store unit.
//
// Handshake: a transfer happens on a rising clock edge where the producer's
// valid and the consumer's ready are both high. A producer holds valid and
// its payload stable until that edge. A consumer may raise or lower ready
// at any time. On the request side the core produces and the LSU consumes.
// On the response side the LSU produces and the core consumes.
interface ram_lsu_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    // LSU side
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
        input  req_wdata_i, rsp_ready_i, ram_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output ram_we_o, ram_addr_o, ram_data_o
    );

    // Core / environment side, which also models the RAM
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
        output req_wdata_i, rsp_ready_i, ram_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/ram_lsu.sv
// Load/store unit for a word-organised RAM with a combinational read and a
// synchronous word write. Sub-word stores are done as read-modify-write.
// All bus outputs are registered. The FSM state is exported on o_dbg_state.
module ram_lsu #(
    parameter int ADDR_LIMIT = 16384
) (
    input  logic       clk,
    input  logic       rst,
    ram_lsu_if.slave   bus,
    output logic [2:0] o_dbg_state
);

    localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic [15:0] r_wdata_lo;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_ram_we;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_data;

    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    // Classify the incoming request; the first matching rule wins.
    always_comb begin
        w_req_err = 1'b0;
        if (bus.req_size_i == 2'b11)
            w_req_err = 1'b1;
        else if (bus.req_addr_i >= LIMIT)
            w_req_err = 1'b1;
        else if (bus.req_size_i == 2'b01 && bus.req_addr_i[0])
            w_req_err = 1'b1;
        else if (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00)
            w_req_err = 1'b1;
    end

    // Little-endian lane selection and extension of the RAM read word.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = bus.ram_data_i[7:0];
            2'd1:    w_byte = bus.ram_data_i[15:8];
            2'd2:    w_byte = bus.ram_data_i[23:16];
            default: w_byte = bus.ram_data_i[31:24];
        endcase
        w_half = r_lane[1] ? bus.ram_data_i[31:16] : bus.ram_data_i[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = bus.ram_data_i;
        endcase
    end

    // Merge the sub-word store operand into the word just read back.
    always_comb begin
        w_merged = bus.ram_data_i;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata_lo[7:0];
                2'd1:    w_merged[15:8]  = r_wdata_lo[7:0];
                2'd2:    w_merged[23:16] = r_wdata_lo[7:0];
                default: w_merged[31:24] = r_wdata_lo[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata_lo;
        end else begin
            w_merged[15:0] = r_wdata_lo;
        end
    end

    // Control FSM; every bus output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_size      <= 2'b00;
            r_lane      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_wdata_lo  <= 16'h0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 32'h0;
            r_ram_data  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_size      <= bus.req_size_i;
                        r_lane      <= bus.req_addr_i[1:0];
                        r_unsigned  <= bus.req_unsigned_i;
                        r_wdata_lo  <= bus.req_wdata_i[15:0];
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            // No RAM access; answer straight away.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                            r_state     <= S_RESP;
                        end else if (!bus.req_we_i) begin
                            r_ram_addr <= {bus.req_addr_i[31:2], 2'b00};
                            r_state    <= S_LOAD;
                        end else if (bus.req_size_i == 2'b10) begin
                            r_ram_addr <= {bus.req_addr_i[31:2], 2'b00};
                            r_ram_we   <= 1'b1;
                            r_ram_data <= bus.req_wdata_i;
                            r_state    <= S_WRITE;
                        end else begin
                            r_ram_addr <= {bus.req_addr_i[31:2], 2'b00};
                            r_state    <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    r_rsp_rdata <= w_load_data;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RMW_RD: begin
                    r_ram_we   <= 1'b1;
                    r_ram_data <= w_merged;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    r_ram_we    <= 1'b0;
                    r_ram_data  <= 32'h0;
                    r_rsp_rdata <= 32'h0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_ram_we    <= 1'b0;
                    r_ram_data  <= 32'h0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = r_req_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.ram_we_o    = r_ram_we;
    assign bus.ram_addr_o  = r_ram_addr;
    assign bus.ram_data_o  = r_ram_data;
    assign o_dbg_state     = r_state;

endmodule
